seq_detect_ctrl: RTL
====================

// Module: seq_detect_ctrl
// PURPOSE
//  Controller that feeds a programmable serial pattern detector from a word stream.
//  - Accepts parallel words over a valid/ready handshake and serialises them one bit per clock.
//  - Matches the bit stream against a run-time pattern (length, overlap mode), counts detections.
//  - Raises a sticky interrupt at a programmable count threshold. Sits between a word source and the
//    status/interrupt logic; replaces fixed-pattern Mealy detectors with one configurable block.
// PARAMETERS
//  WORD_W   8  width of input words (bits serialised per word)
//  PAT_MAX  8  maximum pattern length in bits
//  CNT_W    8  width of detection counter and threshold
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  rst          in   1        asynchronous, active-low reset
//  start        in   1        pulse: latch cfg_* and arm (ignored unless IDLE)
//  stop         in   1        pulse: return to IDLE after current word completes
//  cfg_pattern  in   PAT_MAX  pattern; bit[cfg_len-1] = first bit received, bit[0] = last
//  cfg_len      in   4        pattern length, 1..PAT_MAX; 0 or >PAT_MAX disables detection
//  cfg_overlap  in   1        1 = overlapping matches, 0 = non-overlapping
//  cfg_thresh   in   CNT_W    irq threshold; 0 disables irq
//  in_valid     in   1        source has a word
//  in_data      in   WORD_W   word to serialise
//  in_ready     out  1        block accepts a word this cycle
//  det_pulse    out  1        1-cycle pulse, registered, cycle after the bit completing a match
//  det_count    out  CNT_W    detections since start, saturating at all-ones
//  irq          out  1        sticky, set when det_count becomes equal to cfg_thresh
//  irq_clr      in   1        clears irq
//  busy         out  1        high in any state except IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; in_ready, det_pulse, irq, busy=0; det_count=0; history/fill=0.
//  - FSM states:
//    - IDLE: start -> ARM; latch cfg_*, clear det_count, irq, history.
//    - ARM: in_ready=1; in_valid&in_ready -> SHIFT, load shift reg, bit_cnt=WORD_W-1;
//      stop (no handshake) -> IDLE.
//    - SHIFT: one bit per cycle into matcher, MSB first. After last bit -> ARM, or -> IDLE if stop
//      was seen during the word (stop latched).
//    - cfg_* changes while busy are ignored; start while busy is ignored.
//  - Timing: in_ready is low during SHIFT. Throughput = WORD_W+1 cycles/word.
//    det_pulse latency = 1 cycle after the matching bit.
//  - Matcher: hist shifts left, new bit at LSB; fill counts valid bits, saturating at PAT_MAX.
//    - Match when fill+1 >= cfg_len and {hist,bit}[cfg_len-1:0] == cfg_pattern[cfg_len-1:0].
//    - On match: overlap=1 keeps hist/fill; overlap=0 clears hist and fill to 0.
//    - History persists across word boundaries and ARM bubbles; cleared only on start/reset.
//  - Counter: +1 per match, saturates at 2^CNT_W-1 (no wrap).
//  - irq: set on the cycle det_count transitions to cfg_thresh (thresh!=0). Set has priority over
//    irq_clr in the same cycle. irq does not re-assert while count stays at or above thresh.
//  - Reset mid-SHIFT aborts the word; no partial state survives.
// CONFIGURATION
//  - SEQ_CTRL_LSB_FIRST_EN defined: words serialised LSB first (in_data[0] first).
//  - Not defined: MSB first (in_data[WORD_W-1] first). Matcher and all timing unchanged.
// TESTING
//  1. pattern=8'h35, len=6, overlap=0, word 8'b11010100 -> one det_pulse, 1 cycle after 6th bit;
//     det_count=1.
//  2. pattern=3'b101, len=3, word 8'hAA: overlap=1 -> det_count=3 (bits 3,5,7);
//     overlap=0 -> det_count=2 (bits 3,7).
//  3. pattern=4'hF, len=4, words 8'h03 then 8'hC0 -> single match at 2nd bit of 2nd word
//     (cross-word history); det_count=1.
//  4. thresh=2, drive irq_clr in the cycle count hits 2 -> irq=1; irq_clr a later cycle -> irq=0;
//     3rd match -> irq stays 0.
//  5. rst low mid-SHIFT -> in_ready, busy, det_pulse, irq, det_count all 0 immediately; in_valid
//     ignored until start.
//  6. With SEQ_CTRL_LSB_FIRST_EN: pattern=8'h35, len=6, word 8'b00101011 -> det_count=1;
//     without the macro the same word -> det_count=0.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// Word-stream serialiser feeding a run-time programmable serial pattern detector with
// saturating detection counter and sticky threshold interrupt. Define SEQ_CTRL_LSB_FIRST_EN for LSB-first serialisation.
module seq_detect_ctrl #(
  parameter int unsigned WORD_W  = 8,
  parameter int unsigned PAT_MAX = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_thresh,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  output logic               in_ready,
  output logic               det_pulse,
  output logic [CNT_W-1:0]   det_count,
  output logic               irq,
  input  logic               irq_clr,
  output logic               busy
);

  localparam int unsigned BC_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned FILL_W = $clog2(PAT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_SHIFT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PAT_MAX-1:0]  r_pattern;
  logic [3:0]          r_len;
  logic                r_overlap;
  logic [CNT_W-1:0]    r_thresh;
  logic [WORD_W-1:0]   r_sreg;
  logic [BC_W-1:0]     r_bit_cnt;
  logic                r_stop_pend;
  logic [PAT_MAX-2:0]  r_hist;
  logic [FILL_W-1:0]   r_fill;
  logic                r_det;
  logic [CNT_W-1:0]    r_count;
  logic                r_irq;

  logic                w_start_go;
  logic                w_load;
  logic                w_shift;
  logic                w_bit;
  logic [WORD_W-1:0]   w_sreg_nxt;
  logic [PAT_MAX-1:0]  w_cat;
  logic [PAT_MAX-1:0]  w_mask;
  logic                w_len_ok;
  logic                w_fill_ok;
  logic                w_match;
  logic                w_irq_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_go  = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ARM;
          w_start_go  = 1'b1;
        end
      end
      S_ARM: begin
        if (in_valid) begin
          w_state_nxt = S_SHIFT;
          w_load      = 1'b1;
        end else if (stop) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        // a stop arriving on the final bit still counts as seen during the word
        if (r_bit_cnt == '0) w_state_nxt = (r_stop_pend || stop) ? S_IDLE : S_ARM;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
`ifdef SEQ_CTRL_LSB_FIRST_EN
    w_bit      = r_sreg[0];
    w_sreg_nxt = {1'b0, r_sreg[WORD_W-1:1]};
`else
    w_bit      = r_sreg[WORD_W-1];
    w_sreg_nxt = {r_sreg[WORD_W-2:0], 1'b0};
`endif
    w_cat  = {r_hist, w_bit};
    w_mask = '0;
    for (int unsigned i = 0; i < PAT_MAX; i++) w_mask[i] = (i < 32'(r_len));
    w_len_ok  = (r_len != '0) && (32'(r_len) <= PAT_MAX);
    w_fill_ok = (32'(r_fill) + 32'd1) >= 32'(r_len);
    w_match   = w_shift && w_len_ok && w_fill_ok && (((w_cat ^ r_pattern) & w_mask) == '0);
    w_irq_set = w_match && (r_count != '1) && (r_thresh != '0) &&
                ((r_count + CNT_W'(1)) == r_thresh);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pattern   <= '0;
      r_len       <= '0;
      r_overlap   <= 1'b0;
      r_thresh    <= '0;
      r_sreg      <= '0;
      r_bit_cnt   <= '0;
      r_stop_pend <= 1'b0;
      r_hist      <= '0;
      r_fill      <= '0;
      r_det       <= 1'b0;
      r_count     <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_det <= w_match;
      if (w_start_go) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_thresh  <= cfg_thresh;
        r_count   <= '0;
        r_irq     <= 1'b0;
        r_hist    <= '0;
        r_fill    <= '0;
      end else begin
        if (w_load) begin
          r_sreg      <= in_data;
          r_bit_cnt   <= BC_W'(WORD_W - 1);
          r_stop_pend <= stop;
        end
        if (w_shift) begin
          r_sreg    <= w_sreg_nxt;
          r_bit_cnt <= r_bit_cnt - BC_W'(1);
          if (stop) r_stop_pend <= 1'b1;
          if (w_match && !r_overlap) begin
            r_hist <= '0;
            r_fill <= '0;
          end else begin
            r_hist <= w_cat[PAT_MAX-2:0];
            if (r_fill != FILL_W'(PAT_MAX)) r_fill <= r_fill + FILL_W'(1);
          end
          if (w_match && (r_count != '1)) r_count <= r_count + CNT_W'(1);
        end
        if (w_irq_set)    r_irq <= 1'b1;
        else if (irq_clr) r_irq <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == S_ARM);
  assign busy      = (r_state != S_IDLE);
  assign det_pulse = r_det;
  assign det_count = r_count;
  assign irq       = r_irq;

endmodule
